// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: FSM states and operation codes.
package mdu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mult_div_seq_if.sv
// Request/result bundle between the control unit (master) and the mult/div sequencer (slave).
interface mult_div_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mdu_step.sv
// One combinational iteration: radix-2 Booth step for MULT, restoring step for DIV.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             op,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   acc_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             q_m1_nxt
);
  logic [WIDTH:0] m_sx;
  logic [WIDTH:0] m_zx;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;

  always_comb begin
    m_sx     = {m[WIDTH-1], m};
    m_zx     = {1'b0, m};
    sum      = acc;
    shl      = '0;
    acc_nxt  = acc;
    q_nxt    = q;
    q_m1_nxt = q_m1;
    if (op == OP_MULT) begin
      case ({q[0], q_m1})
        2'b10:   sum = acc - m_sx;
        2'b01:   sum = acc + m_sx;
        default: sum = acc;
      endcase
      // Arithmetic right shift of {acc, Q, q-1}.
      {acc_nxt, q_nxt, q_m1_nxt} = {sum[WIDTH], sum, q};
    end else begin
      shl   = {acc[WIDTH-1:0], q[WIDTH-1]};
      q_nxt = {q[WIDTH-2:0], 1'b0};
      if (shl >= m_zx) begin
        acc_nxt  = shl - m_zx;
        q_nxt[0] = 1'b1;
      end else begin
        acc_nxt = shl;
      end
      q_m1_nxt = 1'b0;
    end
  end
endmodule

// File: rtl/mult_div_seq.sv
// Multicycle signed MULT/DIV sequencer owning the HI/LO result path.
module mult_div_seq
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic           clk,
  input logic           reset,
  mult_div_seq_if.slave bus
);
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             op_q;
  logic             q_m1_q;
  logic             neg_q;
  logic             sa_q;
  logic             dz_q;
  logic             done_q;
  logic             div_zero_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH:0]   acc_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             q_m1_nxt;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign a_abs = bus.a_in[WIDTH-1] ? (~bus.a_in + 1'b1) : bus.a_in;
  assign b_abs = bus.b_in[WIDTH-1] ? (~bus.b_in + 1'b1) : bus.b_in;

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op      (op_q),
    .acc     (acc_q),
    .q       (q_q),
    .q_m1    (q_m1_q),
    .m       (m_q),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt),
    .q_m1_nxt(q_m1_nxt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULT;
      q_m1_q     <= 1'b0;
      neg_q      <= 1'b0;
      sa_q       <= 1'b0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      acc_q      <= '0;
      q_q        <= '0;
      m_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            acc_q  <= '0;
            q_m1_q <= 1'b0;
            cnt_q  <= '0;
            sa_q   <= bus.a_in[WIDTH-1];
            neg_q  <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            dz_q   <= 1'b0;
            if (bus.op == OP_MULT) begin
              m_q     <= bus.a_in;
              q_q     <= bus.b_in;
              state_q <= MULT;
            end else if (bus.b_in == '0) begin
              dz_q    <= 1'b1;
              state_q <= DONE;
            end else begin
              m_q     <= b_abs;
              q_q     <= a_abs;
              state_q <= DIV;
            end
          end
        end
        MULT, DIV: begin
          acc_q  <= acc_nxt;
          q_q    <= q_nxt;
          q_m1_q <= q_m1_nxt;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= FIX;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            hi_q <= acc_q[WIDTH-1:0];
            lo_q <= q_q;
          end else begin
            // Truncating division: quotient sign from a^b, remainder sign from a.
            lo_q <= neg_q ? (~q_q + 1'b1) : q_q;
            hi_q <= sa_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
          end
          state_q <= DONE;
        end
        DONE: begin
          done_q     <= 1'b1;
          div_zero_q <= dz_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: driver pushes model results, negedge monitor checks done.
module tb_mult_div_seq;
  import mdu_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;
  exp_t sb[$];

  mult_div_seq_if #(.WIDTH(32)) bus ();

  mult_div_seq #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from plain signed arithmetic (truncating division, 64-bit to avoid overflow).
  function automatic exp_t model(input logic op_v, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sbv;
    logic [63:0] p;
    logic [63:0] qq;
    logic [63:0] rr;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dz  = 1'b0;
    e.cyc = 0;
    if (op_v == OP_MULT) begin
      p    = 64'(sa * sbv);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.dz = 1'b1;
      e.hi = last_hi;
      e.lo = last_lo;
    end else begin
      qq   = 64'(sa / sbv);
      rr   = 64'(sa % sbv);
      e.hi = rr[31:0];
      e.lo = qq[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("hi", bus.hi_out, e.hi);
        chk("lo", bus.lo_out, e.lo);
        chk("div_zero", 32'(bus.div_zero), 32'(e.dz));
        chk("latency", 32'(cyc), 32'(e.cyc));
        chk("busy_at_done", 32'(bus.busy), 32'd0);
      end
    end
  end

  task automatic issue(input logic op_v, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(op_v, a, b);
    @(negedge clk);
    bus.op    = op_v;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    e.cyc = cyc + 1 + (e.dz ? 1 : 34);
    sb.push_back(e);
    if (!e.dz) begin
      last_hi = e.hi;
      last_lo = e.lo;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 1'($urandom);
    bus.a_in  = $urandom;
    bus.b_in  = $urandom;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done want done within 200 cycles");
      sb.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h8000_0000;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'($signed($urandom_range(0, 40)) - 20);
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic        op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    bus.start = 1'b0;
    bus.op    = OP_MULT;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_div_zero", 32'(bus.div_zero), 32'd0);
    chk("rst_hi", bus.hi_out, 32'd0);
    chk("rst_lo", bus.lo_out, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    issue(OP_MULT, 32'd7, 32'hFFFF_FFFD);
    wait_idle();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle();
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle();
    issue(OP_DIV, 32'd5, 32'd0);
    wait_idle();
    issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_idle();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();

    // Starts while busy must be ignored.
    issue(OP_MULT, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIV;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Reset mid-DIV aborts with no done.
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_div_zero", 32'(bus.div_zero), 32'd0);
    chk("abort_hi", bus.hi_out, 32'd0);
    chk("abort_lo", bus.lo_out, 32'd0);
    sb.delete();
    last_hi = '0;
    last_lo = '0;
    reset = 1'b1;
    repeat (40) @(negedge clk);
    issue(OP_DIV, 32'd9, 32'd0);
    wait_idle();
    issue(OP_MULT, 32'd2, 32'd2);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      op_r = 1'($urandom_range(0, 1));
      a_r  = pick();
      b_r  = pick();
      if (op_r == OP_DIV && $urandom_range(0, 7) == 0) b_r = 32'd0;
      issue(op_r, a_r, b_r);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
